// File: rtl/seq_mult_core_pkg.sv
// Shared widths, constants and FSM state type for the sequential multiplier.
package seq_mult_core_pkg;

  localparam int DW    = 8;
  localparam int DW_2  = 2 * DW;
  localparam int CNT_W = $clog2(DW);

  localparam logic [DW_2-1:0]  ZERO     = '0;
  localparam logic [DW_2-1:0]  ONE      = DW_2'(1);
  localparam logic             BIT_ZERO = 1'b0;
  localparam logic             BIT_ONE  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_mult_core_mag.sv
// Combinational magnitude and sign split of a DW-bit operand; passes through when unsigned.
module twos_comp_mag
  import seq_mult_core_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] mag,
  output logic          sign
);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    sign = SIGNED ? x[DW-1] : BIT_ZERO;
    mag  = sign ? -x : x;
  end

endmodule

// File: rtl/seq_mult_core.sv
// Shift-add multiplier: magnitudes are multiplied over DW fixed cycles, sign applied at the end.
module seq_mult_core
  import seq_mult_core_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            charged,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW_2-1:0] multiplicand,
  output logic            busy,
  output logic            ready,
  output logic [DW_2-1:0] product
);

  mult_state_t      state, state_next;
  logic [DW_2-1:0]  acc;
  logic [DW_2-1:0]  mcand;
  logic [DW-1:0]    mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [DW-1:0]    mplier_mag, mcand_mag;
  logic             mplier_sign, mcand_sign;

  // Upper multiplicand bits carry no meaning for this datapath.
  logic             mcand_hi_unused;
  assign mcand_hi_unused = ^multiplicand[DW_2-1:DW];

  twos_comp_mag #(.SIGNED(SIGNED)) u_mplier_mag (
    .x    (multiplier),
    .mag  (mplier_mag),
    .sign (mplier_sign)
  );

  twos_comp_mag #(.SIGNED(SIGNED)) u_mcand_mag (
    .x    (multiplicand[DW-1:0]),
    .mag  (mcand_mag),
    .sign (mcand_sign)
  );

  // NOTE: next-state is assigned a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (charged) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready   <= BIT_ZERO;
      product <= ZERO;
      acc     <= ZERO;
      mcand   <= ZERO;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= BIT_ZERO;
    end else begin
      state <= state_next;
      ready <= BIT_ZERO;
      case (state)
        IDLE: begin
          if (charged) begin
            mplier <= mplier_mag;
            mcand  <= {{DW{BIT_ZERO}}, mcand_mag};
            neg    <= mplier_sign ^ mcand_sign;
            acc    <= ZERO;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          product <= neg ? (ZERO - acc) : acc;
          ready   <= BIT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Drives a signed and an unsigned multiplier with shared stimulus and checks against integer products.
module tb_seq_mult_core;
  import seq_mult_core_pkg::*;

  logic            clk;
  logic            rst;
  logic            charged;
  logic [DW-1:0]   multiplier;
  logic [DW_2-1:0] multiplicand;
  logic            busy_s, ready_s, busy_u, ready_u;
  logic [DW_2-1:0] product_s, product_u;

  int checks   = 0;
  int failures = 0;

  logic [DW_2-1:0] held_s, held_u;

  seq_mult_core #(.SIGNED(1'b1)) u_signed (
    .clk          (clk),
    .rst          (rst),
    .charged      (charged),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy_s),
    .ready        (ready_s),
    .product      (product_s)
  );

  seq_mult_core #(.SIGNED(1'b0)) u_unsigned (
    .clk          (clk),
    .rst          (rst),
    .charged      (charged),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy_u),
    .ready        (ready_u),
    .product      (product_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW_2-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input bit sgn);
    int sa, sb;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    return DW_2'(sa * sb);
  endfunction

  // Starts one operation and checks every cycle until the result cycle; returns on the
  // cycle in which ready is high, so a following call starts back-to-back.
  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW_2-1:0] b,
                        input bit glitch);
    logic [DW_2-1:0] exp_s, exp_u;
    exp_s = ref_mul(a, b[DW-1:0], 1'b1);
    exp_u = ref_mul(a, b[DW-1:0], 1'b0);
    @(negedge clk);
    charged      = 1'b1;
    multiplier   = a;
    multiplicand = b;
    @(posedge clk);
    #1;
    charged      = 1'b0;
    multiplier   = DW'($urandom);
    multiplicand = DW_2'($urandom);
    check({tag, "_busy_start"}, {busy_s, busy_u}, 2'b11);
    for (int c = 1; c <= DW + 1; c++) begin
      if (glitch && c == 3) begin
        charged      = 1'b1;
        multiplier   = DW'($urandom);
        multiplicand = DW_2'($urandom);
      end else begin
        charged = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c <= DW) begin
        check({tag, "_busy"}, {busy_s, busy_u}, 2'b11);
        check({tag, "_no_ready"}, {ready_s, ready_u}, 2'b00);
        check({tag, "_held_s"}, product_s, held_s);
        check({tag, "_held_u"}, product_u, held_u);
      end else begin
        check({tag, "_idle"}, {busy_s, busy_u}, 2'b00);
        check({tag, "_ready"}, {ready_s, ready_u}, 2'b11);
        check({tag, "_prod_s"}, product_s, exp_s);
        check({tag, "_prod_u"}, product_u, exp_u);
      end
    end
    charged = 1'b0;
    held_s  = exp_s;
    held_u  = exp_u;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_ready_low", {ready_s, ready_u, busy_s, busy_u}, 4'b0000);
      check("idle_hold_s", product_s, held_s);
      check("idle_hold_u", product_u, held_u);
    end
  endtask

  initial begin
    rst          = 1'b0;
    charged      = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    held_s       = '0;
    held_u       = '0;
    #1;
    check("reset_outs", {busy_s, ready_s, busy_u, ready_u}, 4'b0000);
    check("reset_prod", {product_s, product_u}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    run_op("m7x6", 8'd7, 16'd6, 1'b0);
    check("spec_7x6", product_s, 16'h002A);
    idle_cycles(1);
    run_op("mneg3x5", 8'hFD, 16'd5, 1'b0);
    check("spec_neg3x5", product_s, 16'hFFF1);
    run_op("mmin_sq", 8'h80, 16'h0080, 1'b0);
    check("spec_min_sq", product_s, 16'h4000);
    run_op("mmin_max", 8'h80, 16'h007F, 1'b0);
    check("spec_min_max", product_s, 16'hC080);
    run_op("mff", 8'hFF, 16'h00FF, 1'b0);
    check("spec_255sq", product_u, 16'hFE01);
    run_op("mzero", 8'h00, 16'd200, 1'b0);
    check("spec_zero", product_u, 16'h0000);
    run_op("mupper", 8'd3, 16'hAB05, 1'b0);
    check("spec_upper", product_s, 16'h000F);
    idle_cycles(1);
    run_op("mglitch", 8'd9, 16'd11, 1'b1);
    idle_cycles(2);

    // Abort during RUN: reset clears everything and no ready appears afterwards.
    @(negedge clk);
    charged      = 1'b1;
    multiplier   = 8'd13;
    multiplicand = 16'd17;
    @(negedge clk);
    charged = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", {busy_s, busy_u}, 2'b11);
    rst = 1'b0;
    #1;
    check("abort_outs", {busy_s, ready_s, busy_u, ready_u}, 4'b0000);
    check("abort_prod", {product_s, product_u}, 32'h0);
    held_s = '0;
    held_u = '0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(DW + 2);
    run_op("m2x2", 8'd2, 16'd2, 1'b0);
    check("spec_2x2", product_s, 16'h0004);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", DW'($urandom), DW_2'($urandom), 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
